// File: rtl/lcd_digit_writer.sv
`default_nettype none
// =============================================================================
// Module   : lcd_digit_writer
// Brief    : HD44780 8-bit write-only driver. Runs power-up init, then writes
//            three ASCII digits at DDRAM_POS per load. Optional macro
//            LCD_PENDING_EN adds a one-deep buffer for loads arriving while busy.
// Revision : 1.0 - initial release
// =============================================================================
module lcd_digit_writer #(
    parameter int unsigned EN_HIGH_CYC    = 25,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLR_WAIT_CYC   = 100000,
    parameter int unsigned PWRUP_WAIT_CYC = 1000000,
    parameter logic [6:0]  DDRAM_POS      = 7'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ascii_hundreds,
    input  logic [7:0] ascii_tens,
    input  logic [7:0] ascii_ones,
    input  logic       load,
    output logic       busy,
    output logic       ready,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on
);

    localparam int unsigned c_max_a   = (EN_HIGH_CYC > CMD_WAIT_CYC) ? EN_HIGH_CYC : CMD_WAIT_CYC;
    localparam int unsigned c_max_b   = (CLR_WAIT_CYC > PWRUP_WAIT_CYC) ? CLR_WAIT_CYC : PWRUP_WAIT_CYC;
    localparam int unsigned c_cnt_max = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int unsigned c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_en_last   = c_cnt_w'(EN_HIGH_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cmd_last  = c_cnt_w'(CMD_WAIT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_clr_last  = c_cnt_w'(CLR_WAIT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_pwr_last  = c_cnt_w'(PWRUP_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_CH0   = 3'd4,
        ST_CH1   = 3'd5,
        ST_CH2   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_PULSE = 2'd1,
        PH_HOLD  = 2'd2
    } phase_t;

    state_t             r_state, w_state_n;
    phase_t             r_phase, w_phase_n;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_n;
    logic [1:0]         r_idx, w_idx_n;
    logic               w_ready_n;
    logic [7:0]         r_hun, r_ten, r_one;
    logic               w_cap_en;
    logic [7:0]         w_cap_hun, w_cap_ten, w_cap_one;
    logic               w_pend_n;
    logic [8:0]         w_cur, w_nxt;
    logic [c_cnt_w-1:0] w_hold_last;
    logic               w_is_byte_n;

`ifdef LCD_PENDING_EN
    logic       r_pend;
    logic [7:0] r_buf_hun, r_buf_ten, r_buf_one;
`endif

    // {rs, data} driven on the bus while in a given byte-writing state
    function automatic logic [8:0] byte_for(input state_t st, input logic [1:0] idx,
                                            input logic [7:0] h, input logic [7:0] t,
                                            input logic [7:0] o);
        logic [8:0] v;
        v = 9'h000;
        case (st)
            ST_INIT: begin
                case (idx)
                    2'd0:    v = {1'b0, 8'h38};
                    2'd1:    v = {1'b0, 8'h0C};
                    2'd2:    v = {1'b0, 8'h06};
                    default: v = {1'b0, 8'h01};
                endcase
            end
            ST_ADDR: v = {1'b0, 1'b1, DDRAM_POS};
            ST_CH0:  v = {1'b1, h};
            ST_CH1:  v = {1'b1, t};
            ST_CH2:  v = {1'b1, o};
            default: v = 9'h000;
        endcase
        return v;
    endfunction

    assign w_cur       = byte_for(r_state, r_idx, r_hun, r_ten, r_one);
    assign w_hold_last = (w_cur == 9'h001) ? c_clr_last : c_cmd_last;

    always_comb begin
        w_state_n = r_state;
        w_phase_n = r_phase;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_ready_n = ready;
        w_cap_en  = 1'b0;
        w_cap_hun = ascii_hundreds;
        w_cap_ten = ascii_tens;
        w_cap_one = ascii_ones;

        case (r_state)
            ST_PWRUP: begin
                if (r_cnt == c_pwr_last) begin
                    w_state_n = ST_INIT;
                    w_phase_n = PH_SETUP;
                    w_cnt_n   = '0;
                    w_idx_n   = 2'd0;
                end else begin
                    w_cnt_n = r_cnt + c_one;
                end
            end
            ST_IDLE: begin
                if (load) begin
                    w_cap_en  = 1'b1;
                    w_state_n = ST_ADDR;
                    w_phase_n = PH_SETUP;
                    w_cnt_n   = '0;
`ifdef LCD_PENDING_EN
                end else if (r_pend) begin
                    w_cap_en  = 1'b1;
                    w_cap_hun = r_buf_hun;
                    w_cap_ten = r_buf_ten;
                    w_cap_one = r_buf_one;
                    w_state_n = ST_ADDR;
                    w_phase_n = PH_SETUP;
                    w_cnt_n   = '0;
`endif
                end
            end
            ST_INIT, ST_ADDR, ST_CH0, ST_CH1, ST_CH2: begin
                case (r_phase)
                    PH_SETUP: begin
                        w_phase_n = PH_PULSE;
                        w_cnt_n   = '0;
                    end
                    PH_PULSE: begin
                        if (r_cnt == c_en_last) begin
                            w_phase_n = PH_HOLD;
                            w_cnt_n   = '0;
                        end else begin
                            w_cnt_n = r_cnt + c_one;
                        end
                    end
                    default: begin
                        if (r_cnt == w_hold_last) begin
                            w_phase_n = PH_SETUP;
                            w_cnt_n   = '0;
                            case (r_state)
                                ST_INIT: begin
                                    if (r_idx == 2'd3) begin
                                        w_state_n = ST_IDLE;
                                        w_ready_n = 1'b1;
                                    end else begin
                                        w_idx_n = r_idx + 2'd1;
                                    end
                                end
                                ST_ADDR: w_state_n = ST_CH0;
                                ST_CH0:  w_state_n = ST_CH1;
                                ST_CH1:  w_state_n = ST_CH2;
                                default: w_state_n = ST_IDLE;
                            endcase
                        end else begin
                            w_cnt_n = r_cnt + c_one;
                        end
                    end
                endcase
            end
            default: w_state_n = ST_PWRUP;
        endcase

`ifdef LCD_PENDING_EN
        // In IDLE the flag is consumed either by the buffer or by a fresh load
        w_pend_n = r_pend;
        if (load && (r_state != ST_IDLE)) begin
            w_pend_n = 1'b1;
        end else if (r_state == ST_IDLE) begin
            w_pend_n = 1'b0;
        end
`else
        w_pend_n = 1'b0;
`endif
    end

    assign w_nxt       = byte_for(w_state_n, w_idx_n, r_hun, r_ten, r_one);
    assign w_is_byte_n = (w_state_n != ST_PWRUP) && (w_state_n != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_PWRUP;
            r_phase  <= PH_SETUP;
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_hun    <= 8'h00;
            r_ten    <= 8'h00;
            r_one    <= 8'h00;
            ready    <= 1'b0;
            busy     <= 1'b1;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            r_state <= w_state_n;
            r_phase <= w_phase_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            ready   <= w_ready_n;
            busy    <= (w_state_n != ST_IDLE) || w_pend_n;
            if (w_cap_en) begin
                r_hun <= w_cap_hun;
                r_ten <= w_cap_ten;
                r_one <= w_cap_one;
            end
            // Bus outputs are registered from next-state so they change cleanly on the edge
            lcd_en <= w_is_byte_n && (w_phase_n == PH_PULSE);
            if (w_is_byte_n) begin
                lcd_rs   <= w_nxt[8];
                lcd_data <= w_nxt[7:0];
            end
        end
    end

`ifdef LCD_PENDING_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend    <= 1'b0;
            r_buf_hun <= 8'h00;
            r_buf_ten <= 8'h00;
            r_buf_one <= 8'h00;
        end else begin
            r_pend <= w_pend_n;
            if (load && (r_state != ST_IDLE)) begin
                r_buf_hun <= ascii_hundreds;
                r_buf_ten <= ascii_tens;
                r_buf_one <= ascii_ones;
            end
        end
    end
`endif

    assign lcd_rw = 1'b0;
    assign lcd_on = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_lcd_digit_writer.sv
`default_nettype none
// =============================================================================
// Module   : tb_lcd_digit_writer
// Brief    : Scoreboard bench for lcd_digit_writer; two instances (DDRAM 00/45).
// Revision : 1.0 - initial release
// =============================================================================
module tb_lcd_digit_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ascii_hundreds, ascii_tens, ascii_ones;
    logic       load;

    logic       busy0, ready0, rs0, rw0, en0, on0;
    logic [7:0] data0;
    logic       busy1, ready1, rs1, rw1, en1, on1;
    logic [7:0] data1;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];

    logic       m_prev[2];
    int         m_len[2];
    logic [8:0] m_lat[2];
    bit         m_unst[2];
    bit         ignore_len = 1'b0;

    always #5 clk = ~clk;

    lcd_digit_writer #(
        .EN_HIGH_CYC(2), .CMD_WAIT_CYC(4), .CLR_WAIT_CYC(8), .PWRUP_WAIT_CYC(10), .DDRAM_POS(7'h00)
    ) dut0 (
        .clk(clk), .rst(rst), .ascii_hundreds(ascii_hundreds), .ascii_tens(ascii_tens),
        .ascii_ones(ascii_ones), .load(load), .busy(busy0), .ready(ready0), .lcd_data(data0),
        .lcd_rs(rs0), .lcd_rw(rw0), .lcd_en(en0), .lcd_on(on0)
    );

    lcd_digit_writer #(
        .EN_HIGH_CYC(2), .CMD_WAIT_CYC(4), .CLR_WAIT_CYC(8), .PWRUP_WAIT_CYC(10), .DDRAM_POS(7'h45)
    ) dut1 (
        .clk(clk), .rst(rst), .ascii_hundreds(ascii_hundreds), .ascii_tens(ascii_tens),
        .ascii_ones(ascii_ones), .load(load), .busy(busy1), .ready(ready1), .lcd_data(data1),
        .lcd_rs(rs1), .lcd_rw(rw1), .lcd_en(en1), .lcd_on(on1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Byte monitor: pops the scoreboard on each en rise, checks pulse width and bus stability
    task automatic mon_step(input int id, input logic en, input logic rs, input logic [7:0] data,
                            input logic rw, input logic on);
        int         n;
        logic [8:0] e;
        if (en && !m_prev[id]) begin
            n = (id == 0) ? q0.size() : q1.size();
            check_val($sformatf("byte_expected%0d", id), (n > 0) ? 32'd1 : 32'd0, 32'd1);
            if (n > 0) begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                check_val($sformatf("byte%0d", id), {23'd0, rs, data}, {23'd0, e});
            end
            check_val($sformatf("rw_on%0d", id), {30'd0, rw, on}, 32'd1);
            m_len[id]  = 1;
            m_lat[id]  = {rs, data};
            m_unst[id] = 1'b0;
        end else if (en) begin
            m_len[id]++;
            if ({rs, data} != m_lat[id]) m_unst[id] = 1'b1;
        end else if (m_prev[id] && !ignore_len) begin
            check_val($sformatf("en_len%0d", id), m_len[id], 32'd2);
            check_val($sformatf("stable%0d", id), {31'd0, m_unst[id]}, 32'd0);
        end
        m_prev[id] = en;
    endtask

    always @(negedge clk) mon_step(0, en0, rs0, data0, rw0, on0);
    always @(negedge clk) mon_step(1, en1, rs1, data1, rw1, on1);

    task automatic push_both(input logic [8:0] v0, input logic [8:0] v1);
        q0.push_back(v0);
        q1.push_back(v1);
    endtask

    task automatic push_init();
        push_both(9'h038, 9'h038);
        push_both(9'h00C, 9'h00C);
        push_both(9'h006, 9'h006);
        push_both(9'h001, 9'h001);
    endtask

    // Called at the negedge where rst was just dropped
    task automatic wait_ready();
        repeat (41) @(posedge clk);
        @(negedge clk);
        check_val("ready_before", {30'd0, ready0, ready1}, 32'd0);
        check_val("busy_before", {30'd0, busy0, busy1}, 32'd3);
        @(posedge clk);
        @(negedge clk);
        check_val("ready_after", {30'd0, ready0, ready1}, 32'd3);
        check_val("busy_after_init", {30'd0, busy0, busy1}, 32'd0);
    endtask

    // Issue load at a negedge in IDLE; push the first n bytes expected of the update
    task automatic start_load(input logic [7:0] h, input logic [7:0] t, input logic [7:0] o, input int n);
        ascii_hundreds = h;
        ascii_tens     = t;
        ascii_ones     = o;
        load           = 1'b1;
        if (n >= 1) push_both(9'h080, 9'h0C5);
        if (n >= 2) push_both({1'b1, h}, {1'b1, h});
        if (n >= 3) push_both({1'b1, t}, {1'b1, t});
        if (n >= 4) push_both({1'b1, o}, {1'b1, o});
        @(negedge clk);
        load           = 1'b0;
        ascii_hundreds = 8'hAA;
        ascii_tens     = 8'h55;
        ascii_ones     = 8'h5A;
        check_val("busy_after_load", {30'd0, busy0, busy1}, 32'd3);
    endtask

    task automatic wait_busy_end(input int n);
        repeat (n - 1) @(negedge clk);
        check_val("busy_last", {30'd0, busy0, busy1}, 32'd3);
        @(negedge clk);
        check_val("busy_fall", {30'd0, busy0, busy1}, 32'd0);
    endtask

    initial begin
        m_prev[0] = 1'b0; m_prev[1] = 1'b0;
        m_len[0] = 0; m_len[1] = 0;
        rst = 1'b1;
        load = 1'b0;
        ascii_hundreds = 8'h00;
        ascii_tens = 8'h00;
        ascii_ones = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_data", {24'd0, data0}, 32'h00);
        check_val("rst_ctrl", {27'd0, rs0, rw0, en0, on0, busy0}, 32'b00011);
        check_val("rst_ready", {31'd0, ready0}, 32'd0);

        // power-up init
        push_init();
        rst = 1'b0;
        wait_ready();

        // plain update, DDRAM position 00 / 45, verbatim codes incl. 01
        start_load(8'h31, 8'h32, 8'h37, 4);
        wait_busy_end(28);
        start_load(8'h30, 8'h30, 8'h30, 4);
        wait_busy_end(28);
        start_load(8'h03, 8'h01, 8'hFF, 4);
        wait_busy_end(28);

        // load arriving 5 clocks into an update
        start_load(8'h34, 8'h35, 8'h36, 4);
        repeat (4) @(negedge clk);
        ascii_hundreds = 8'h39;
        ascii_tens     = 8'h39;
        ascii_ones     = 8'h39;
        load           = 1'b1;
`ifdef LCD_PENDING_EN
        push_both(9'h080, 9'h0C5);
        push_both(9'h139, 9'h139);
        push_both(9'h139, 9'h139);
        push_both(9'h139, 9'h139);
`endif
        @(negedge clk);
        load = 1'b0;
        ascii_hundreds = 8'h11;
`ifdef LCD_PENDING_EN
        wait_busy_end(52);
`else
        wait_busy_end(23);
`endif

        // reset during CH1 pulse: ones digit never written, init repeats
        start_load(8'h35, 8'h36, 8'h38, 3);
        repeat (15) @(negedge clk);
        check_val("ch1_pulse", {31'd0, en0}, 32'd1);
        ignore_len = 1'b1;
        rst = 1'b1;
        push_init();
        @(negedge clk);
        check_val("en_after_rst", {30'd0, en0, en1}, 32'd0);
        check_val("ready_in_rst", {30'd0, ready0, ready1}, 32'd0);
        rst = 1'b0;
        wait_ready();
        ignore_len = 1'b0;

        start_load(8'h39, 8'h38, 8'h37, 4);
        wait_busy_end(28);

        repeat (5) @(negedge clk);
        check_val("q0_drained", q0.size(), 32'd0);
        check_val("q1_drained", q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
